// File: rtl/rv_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   XLEN        : width of write-back values
//   REG_ADDR_W  : width of an architectural register address
//   NREGS       : number of architectural registers (x0 hard-wired zero)
//   arb_state_t : starvation FSM states of the write-port arbiter
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef enum logic [1:0] {
    IDLE,   // no divider result waiting
    WAIT,   // divider result refused at least once, counting
    FORCE   // pipeline frozen, divider owns the write port
  } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Scoreboard for the single outstanding divide.
// Tracks which architectural register the in-flight divide will write and
// flags RAW/WAW hazards for the instruction currently in ID.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   set_en, set_rd        : divide accepted for issue and its destination
//   clr_en, clr_rd        : divider result accepted and its destination
//   rs1/rs2/rd (+ quals)  : ID-stage register addresses and use qualifiers
//   outstanding           : a divide is in flight
//   hazard                : ID instruction touches a busy register
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS = rv_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic                  rs1_used,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  rd_valid,
  output logic                  outstanding,
  output logic                  hazard
);

  logic [NREGS-1:0] busy;

  // NOTE: busy is a small flop vector, not a RAM, so it is cleared on reset
  // like any other control state; a divide in flight at reset is forgotten.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      outstanding <= 1'b0;
    end else begin
      // Clear before set so that a set in the same cycle takes precedence.
      if (clr_en) begin
        busy[clr_rd] <= 1'b0;
        outstanding  <= 1'b0;
      end
      if (set_en) begin
        outstanding <= 1'b1;
        // x0 is never marked busy, so reads of x0 never stall.
        if (set_rd != '0) busy[set_rd] <= 1'b1;
      end
    end
  end

  assign hazard = (rs1_used & busy[rs1])
                | (rs2_used & busy[rs2])
                | (rd_valid & busy[rd]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter for the ID stage.
// Shares the single register-file write port between the in-order WB stage
// and the multi-cycle divider, keeps the divider scoreboard, and guarantees
// the divider a slot within STARVE_LIMIT blocked cycles by freezing the
// pipeline for one cycle.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   wb_we, wb_rd, wb_data             : pipeline WB write request
//   div_issue, div_issue_rd           : divide leaving ID this cycle
//   div_issue_ready                   : no divide outstanding
//   div_valid, div_rd, div_data       : divider result
//   div_ready                         : divider result accepted this cycle
//   id_rs1/rs2/rd + qualifiers        : ID instruction register usage
//   id_stall                          : ID hazard stall
//   pipe_stall                        : freeze MEM/WB, WB re-presented
//   rf_we, rf_waddr, rf_wd            : register-file write port
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN         = rv_pkg::XLEN,
  parameter int NREGS        = rv_pkg::NREGS,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  div_issue,
  input  logic [REG_ADDR_W-1:0] div_issue_rd,
  output logic                  div_issue_ready,
  input  logic                  div_valid,
  input  logic [REG_ADDR_W-1:0] div_rd,
  input  logic [XLEN-1:0]       div_data,
  output logic                  div_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_rd_valid,
  output logic                  id_stall,
  output logic                  pipe_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wd
);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic wb_eff;
  logic grant_div;
  logic in_force;
  logic outstanding;
  logic hazard;

  // Writes to x0 are discarded, so they never compete for the port.
  assign wb_eff    = wb_we & (wb_rd != '0);
  assign in_force  = (state == FORCE);
  assign grant_div = ~rst & div_valid & (~wb_eff | in_force);

  assign div_ready       = grant_div;
  assign pipe_stall      = ~rst & in_force;
  assign div_issue_ready = ~outstanding;
  assign id_stall        = ~rst & (hazard | in_force);

  // Write-port mux. The register file samples on negedge, so an accepted
  // write lands within the cycle it is presented.
  // NOTE: every output of this block is given a default first so that no
  // path through it leaves a value unassigned and a latch is inferred.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wd    = '0;
    if (grant_div && (div_rd != '0)) begin
      rf_we    = 1'b1;
      rf_waddr = div_rd;
      rf_wd    = div_data;
    end else if (~rst && wb_eff && ~in_force) begin
      rf_we    = 1'b1;
      rf_waddr = wb_rd;
      rf_wd    = wb_data;
    end
  end

  // Starvation FSM: counts consecutive cycles a divider result is refused.
  // NOTE: state registers use non-blocking assignments so every flop in the
  // block updates from the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_valid && !grant_div) begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (grant_div) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(STARVE_LIMIT - 1)) begin
            state <= FORCE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // One frozen cycle hands the port to the divider; a missing
        // div_valid here is a protocol error and simply returns to IDLE.
        FORCE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  rf_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (div_issue & div_issue_ready),
    .set_rd     (div_issue_rd),
    .clr_en     (div_ready & div_valid),
    .clr_rd     (div_rd),
    .rs1        (id_rs1),
    .rs1_used   (id_rs1_used),
    .rs2        (id_rs2),
    .rs2_used   (id_rs2_used),
    .rd         (id_rd),
    .rd_valid   (id_rd_valid),
    .outstanding(outstanding),
    .hazard     (hazard)
  );

  // The issuing stage must wait for div_issue_ready; a divide issued while
  // another is outstanding would be silently dropped.
  a_issue_when_ready: assert property (
    @(posedge clk) disable iff (rst) div_issue |-> div_issue_ready
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, two
// multi-cycle sequences (starvation, reset mid-divide) and a randomized
// phase, all compared against a cycle-level behavioural model.
module tb_rf_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        div_issue;
  logic [4:0]  div_issue_rd;
  logic        div_issue_ready;
  logic        div_valid;
  logic [4:0]  div_rd;
  logic [31:0] div_data;
  logic        div_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rd_valid;
  logic        id_stall, pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .XLEN(32), .NREGS(32), .STARVE_LIMIT(LIMIT), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .div_issue(div_issue), .div_issue_rd(div_issue_rd),
    .div_issue_ready(div_issue_ready),
    .div_valid(div_valid), .div_rd(div_rd), .div_data(div_data),
    .div_ready(div_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_valid(id_rd_valid),
    .id_stall(id_stall), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wd(rf_wd)
  );

  // Register file fed by the write port, sampling on negedge.
  logic [31:0] rf_mem [32];
  always @(negedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wd;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One divide at most in flight: remember whether there is one and where
  // it writes; count consecutive cycles a waiting result has been refused.
  bit          m_out = 1'b0;
  int          m_rd  = 0;
  int          m_blk = 0;
  logic        e_we, e_ready, e_pipe, e_ids, e_ir;
  logic [4:0]  e_addr;
  logic [31:0] e_wd;
  logic        s_we, s_ready, s_pipe, s_ids, s_ir;
  logic [4:0]  s_addr;
  logic [31:0] s_wd;

  function automatic bit reads(input logic [4:0] r, input logic q);
    return q && m_out && (m_rd != 0) && (int'(r) == m_rd);
  endfunction

  task automatic model_eval();
    bit frz, wbe;
    frz     = !rst && (m_blk >= LIMIT);
    wbe     = wb_we && (wb_rd != 0);
    e_ready = !rst && div_valid && (!wbe || frz);
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (e_ready && div_rd != 0) begin
      e_we = 1'b1; e_addr = div_rd; e_wd = div_data;
    end else if (!rst && wbe && !frz) begin
      e_we = 1'b1; e_addr = wb_rd; e_wd = wb_data;
    end
    e_pipe = frz;
    e_ir   = !m_out;
    e_ids  = !rst && (frz || reads(id_rs1, id_rs1_used) ||
                      reads(id_rs2, id_rs2_used) || reads(id_rd, id_rd_valid));
  endtask

  task automatic model_step();
    bit was_out;
    if (rst) begin
      m_out = 1'b0;
      m_blk = 0;
    end else begin
      was_out = m_out;
      if (m_blk >= LIMIT || e_ready) m_blk = 0;
      else if (m_blk > 0 || div_valid) m_blk++;
      if (e_ready) m_out = 1'b0;
      if (div_issue && !was_out) begin
        m_out = 1'b1;
        m_rd  = int'(div_issue_rd);
      end
    end
  endtask

  // Inputs are set by the caller just after a posedge; outputs are sampled
  // and compared on the following negedge, the model advances on posedge.
  task automatic run_cycle(input string tag);
    @(negedge clk);
    model_eval();
    s_we = rf_we; s_addr = rf_waddr; s_wd = rf_wd; s_ready = div_ready;
    s_pipe = pipe_stall; s_ids = id_stall; s_ir = div_issue_ready;
    check($sformatf("%s rf_we", tag), s_we, e_we);
    check($sformatf("%s rf_waddr", tag), s_addr, e_addr);
    check($sformatf("%s rf_wd", tag), s_wd, e_wd);
    check($sformatf("%s div_ready", tag), s_ready, e_ready);
    check($sformatf("%s pipe_stall", tag), s_pipe, e_pipe);
    check($sformatf("%s id_stall", tag), s_ids, e_ids);
    check($sformatf("%s div_issue_ready", tag), s_ir, e_ir);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    div_issue = 0; div_issue_rd = 0;
    div_valid = 0; div_rd = 0; div_data = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rd_valid = 0;
  endtask

  // Divider result held against a WB write every cycle.
  task automatic starve_seq(input logic [4:0] drd, input logic [31:0] ddata);
    idle_inputs(); div_issue = 1; div_issue_rd = drd;
    run_cycle("starve issue");
    idle_inputs();
    div_valid = 1; div_rd = drd; div_data = ddata;
    wb_we = 1; wb_rd = 5'd10;
    for (int k = 0; k < LIMIT; k++) begin
      wb_data = 32'h100 + k;
      run_cycle("starve blocked");
      check("starve wb addr", s_addr, 5'd10);
      check("starve div held", s_ready, 1'b0);
      check("starve no freeze", s_pipe, 1'b0);
    end
    wb_data = 32'h100 + LIMIT;
    run_cycle("starve force");
    check("force pipe_stall", s_pipe, 1'b1);
    check("force id_stall", s_ids, 1'b1);
    check("force div_ready", s_ready, 1'b1);
    check("force addr", s_addr, drd);
    check("force data", s_wd, ddata);
    div_valid = 0;
    run_cycle("starve replay");
    check("replay addr", s_addr, 5'd10);
    check("replay data", s_wd, 32'h100 + LIMIT);
    check("replay pipe_stall", s_pipe, 1'b0);
    check("rf div value", rf_mem[drd], ddata);
    check("rf wb value", rf_mem[10], 32'h100 + LIMIT);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic wb_we; logic [4:0] wb_rd; logic [31:0] wb_data;
    logic div_issue; logic [4:0] div_issue_rd;
    logic div_valid; logic [4:0] div_rd; logic [31:0] div_data;
    logic [4:0] rs1; logic rs1_used; logic [4:0] rd; logic rd_valid;
    logic x_we; logic [4:0] x_addr; logic [31:0] x_wd;
    logic x_ready; logic x_ids; logic x_ir;
  } vec_t;

  vec_t tab [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    bit   pend, dv;
    logic [4:0]  drd;
    logic [31:0] dd;

    // wb         issue    div result     id                expected
    tab[0]  = '{1,5,'h11,  0,0, 0,0,0,     0,0, 0,0,  1,5,'h11, 0,0,1};
    tab[1]  = '{0,0,0,     1,7, 0,0,0,     0,0, 0,0,  0,0,0,    0,0,1};
    tab[2]  = '{0,0,0,     0,0, 0,0,0,     7,1, 0,0,  0,0,0,    0,1,0};
    tab[3]  = '{0,0,0,     0,0, 1,7,42,    7,1, 0,0,  1,7,42,   1,1,0};
    tab[4]  = '{0,0,0,     0,0, 0,0,0,     7,1, 0,0,  0,0,0,    0,0,1};
    tab[5]  = '{0,0,0,     1,4, 0,0,0,     0,0, 4,1,  0,0,0,    0,0,1};
    tab[6]  = '{1,6,'h66,  0,0, 0,0,0,     0,0, 4,1,  1,6,'h66, 0,1,0};
    tab[7]  = '{0,0,0,     0,0, 1,4,'h44,  0,0, 4,1,  1,4,'h44, 1,1,0};
    tab[8]  = '{0,0,0,     0,0, 0,0,0,     0,0, 4,1,  0,0,0,    0,0,1};
    tab[9]  = '{0,0,0,     1,0, 0,0,0,     0,0, 0,0,  0,0,0,    0,0,1};
    tab[10] = '{1,0,'h55,  0,0, 1,0,'h5,   0,1, 0,1,  0,0,0,    1,0,0};
    tab[11] = '{0,0,0,     0,0, 0,0,0,     0,1, 0,1,  0,0,0,    0,0,1};

    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset rf_we", rf_we, 1'b0);
    check("reset div_ready", div_ready, 1'b0);
    check("reset pipe_stall", pipe_stall, 1'b0);
    check("reset id_stall", id_stall, 1'b0);
    check("reset div_issue_ready", div_issue_ready, 1'b1);
    rst = 0;

    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      wb_we = tab[i].wb_we; wb_rd = tab[i].wb_rd; wb_data = tab[i].wb_data;
      div_issue = tab[i].div_issue; div_issue_rd = tab[i].div_issue_rd;
      div_valid = tab[i].div_valid; div_rd = tab[i].div_rd;
      div_data = tab[i].div_data;
      id_rs1 = tab[i].rs1; id_rs1_used = tab[i].rs1_used;
      id_rd = tab[i].rd; id_rd_valid = tab[i].rd_valid;
      run_cycle($sformatf("vec%0d", i));
      check($sformatf("tab%0d rf_we", i), s_we, tab[i].x_we);
      check($sformatf("tab%0d rf_waddr", i), s_addr, tab[i].x_addr);
      check($sformatf("tab%0d rf_wd", i), s_wd, tab[i].x_wd);
      check($sformatf("tab%0d div_ready", i), s_ready, tab[i].x_ready);
      check($sformatf("tab%0d id_stall", i), s_ids, tab[i].x_ids);
      check($sformatf("tab%0d div_issue_ready", i), s_ir, tab[i].x_ir);
    end
    check("rf x5", rf_mem[5], 32'h11);
    check("rf x7", rf_mem[7], 32'd42);
    check("rf x4", rf_mem[4], 32'h44);
    check("rf x6", rf_mem[6], 32'h66);
    check("rf x0", rf_mem[0], 32'h0);

    starve_seq(5'd3, 32'hd1d);

    // Reset while a result is waiting in WAIT with x9 busy.
    idle_inputs(); div_issue = 1; div_issue_rd = 5'd9;
    run_cycle("rst issue");
    idle_inputs();
    div_valid = 1; div_rd = 5'd9; div_data = 32'h99;
    wb_we = 1; wb_rd = 5'd11; wb_data = 32'hb0;
    run_cycle("rst wait0");
    run_cycle("rst wait1");
    rst = 1;
    run_cycle("rst cycle");
    check("rst no write", s_we, 1'b0);
    check("rst no accept", s_ready, 1'b0);
    rst = 0;
    idle_inputs(); id_rs1 = 5'd9; id_rs1_used = 1;
    run_cycle("post rst");
    check("post rst issue_ready", s_ir, 1'b1);
    check("post rst id_stall", s_ids, 1'b0);
    check("post rst pipe_stall", s_pipe, 1'b0);
    check("post rst x9 untouched", rf_mem[9], 32'h0);
    // A full starvation window again shows the counter restarted from 0.
    starve_seq(5'd12, 32'hc0c0);

    // ---------------- randomized phase ----------------
    pend = 0; dv = 0; lat = 0; drd = 0; dd = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      wb_we = ($urandom_range(0, 9) < 7);
      wb_rd = 5'($urandom); wb_data = $urandom;
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_rd_valid = 1'($urandom);
      if (pend) begin
        if (lat == 0) begin pend = 0; dv = 1; dd = $urandom; end
        else lat--;
      end
      div_valid = dv; div_rd = drd; div_data = dd;
      div_issue = 0; div_issue_rd = 5'($urandom);
      if (!rst && !m_out && !pend && !dv && $urandom_range(0, 2) == 0) begin
        div_issue = 1; drd = div_issue_rd;
        pend = 1; lat = $urandom_range(0, 5);
      end
      run_cycle("rand");
      if (rst) begin pend = 0; dv = 0; end
      else if (e_ready) dv = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
